// File: rtl/i2c_slave_port.sv
// I2C target: START/STOP decode, 7-bit address match, write-byte delivery and read-byte serialisation.
// Latency: pads to decisions SYNC_STAGES+FILT_LEN clk; no backpressure (no clock stretching).
module i2c_slave_port #(
    parameter logic [6:0] I2C_ADDR    = 7'h41,
    parameter int         FILT_LEN    = 3,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_first,
    output logic       tx_req,
    input  logic [7:0] tx_data,
    output logic       start_det,
    output logic       stop_det,
    output logic       busy
);

    localparam int              CW      = $clog2(FILT_LEN + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(FILT_LEN - 1);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
    } state_t;

    // index 0 = SCL, index 1 = SDA
    logic [1:0]                  pad;
    logic [1:0][SYNC_STAGES-1:0] sync_q;
    logic [1:0][CW-1:0]          filt_cnt;
    logic [1:0]                  filt_q;
    logic [1:0]                  filt_d;

    assign pad = {sda_i, scl_i};

    // A new level is adopted only after FILT_LEN consecutive disagreeing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= '1;
            filt_cnt <= '0;
            filt_q   <= 2'b11;
            filt_d   <= 2'b11;
        end else begin
            filt_d <= filt_q;
            for (int i = 0; i < 2; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], pad[i]};
                if (sync_q[i][SYNC_STAGES-1] == filt_q[i]) begin
                    filt_cnt[i] <= '0;
                end else if (filt_cnt[i] == CNT_MAX) begin
                    filt_q[i]   <= sync_q[i][SYNC_STAGES-1];
                    filt_cnt[i] <= '0;
                end else begin
                    filt_cnt[i] <= filt_cnt[i] + 1'b1;
                end
            end
        end
    end

    logic scl_f, sda_f, scl_rise, scl_fall, start_c, stop_c;

    assign scl_f    = filt_q[0];
    assign sda_f    = filt_q[1];
    assign scl_rise = scl_f & ~filt_d[0];
    assign scl_fall = ~scl_f & filt_d[0];
    assign start_c  = scl_f & filt_d[0] & filt_d[1] & ~sda_f;
    assign stop_c   = scl_f & filt_d[0] & ~filt_d[1] & sda_f;

    state_t     state, state_nxt;
    logic [3:0] bit_cnt, cnt_nxt;
    logic [7:0] shreg, sh_nxt;
    logic       rw, rw_nxt;
    logic       first_pend, first_nxt;
    logic       oe_nxt, busy_nxt;
    logic [7:0] rx_data_nxt;
    logic       rx_valid_nxt, rx_first_nxt, tx_req_nxt, start_nxt, stop_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            rw         <= 1'b0;
            first_pend <= 1'b0;
            sda_oe     <= 1'b0;
            busy       <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_first   <= 1'b0;
            tx_req     <= 1'b0;
            start_det  <= 1'b0;
            stop_det   <= 1'b0;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= cnt_nxt;
            shreg      <= sh_nxt;
            rw         <= rw_nxt;
            first_pend <= first_nxt;
            sda_oe     <= oe_nxt;
            busy       <= busy_nxt;
            rx_data    <= rx_data_nxt;
            rx_valid   <= rx_valid_nxt;
            rx_first   <= rx_first_nxt;
            tx_req     <= tx_req_nxt;
            start_det  <= start_nxt;
            stop_det   <= stop_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = bit_cnt;
        sh_nxt       = shreg;
        rw_nxt       = rw;
        first_nxt    = first_pend;
        oe_nxt       = sda_oe;
        busy_nxt     = busy;
        rx_data_nxt  = rx_data;
        rx_valid_nxt = 1'b0;
        rx_first_nxt = 1'b0;
        tx_req_nxt   = 1'b0;
        start_nxt    = 1'b0;
        stop_nxt     = 1'b0;

        // START/STOP pre-empt every state, so a partial byte never reaches rx_valid.
        if (stop_c) begin
            oe_nxt    = 1'b0;
            stop_nxt  = 1'b1;
            busy_nxt  = 1'b0;
            first_nxt = 1'b0;
            cnt_nxt   = '0;
            state_nxt = IDLE;
        end else if (start_c) begin
            oe_nxt    = 1'b0;
            start_nxt = 1'b1;
            first_nxt = 1'b0;
            cnt_nxt   = '0;
            state_nxt = ADDR;
        end else begin
            case (state)
                IDLE: ;
                ADDR: begin
                    if (scl_rise) begin
                        sh_nxt  = {shreg[6:0], sda_f};
                        cnt_nxt = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        cnt_nxt = '0;
                        if (shreg[7:1] == I2C_ADDR) begin
                            oe_nxt     = 1'b1;
                            busy_nxt   = 1'b1;
                            rw_nxt     = shreg[0];
                            first_nxt  = 1'b1;
                            tx_req_nxt = 1'b1;
                            state_nxt  = ADDR_ACK;
                        end else begin
                            busy_nxt  = 1'b0;
                            state_nxt = WAIT_STOP;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (rw) begin
                            sh_nxt    = tx_data;
                            oe_nxt    = ~tx_data[7];
                            cnt_nxt   = 4'd1;
                            state_nxt = RD_DATA;
                        end else begin
                            oe_nxt    = 1'b0;
                            cnt_nxt   = '0;
                            state_nxt = WR_DATA;
                        end
                    end
                end
                WR_DATA: begin
                    if (scl_rise) begin
                        sh_nxt  = {shreg[6:0], sda_f};
                        cnt_nxt = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            rx_data_nxt  = {shreg[6:0], sda_f};
                            rx_valid_nxt = 1'b1;
                            rx_first_nxt = first_pend;
                            first_nxt    = 1'b0;
                        end
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        oe_nxt    = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = WR_ACK;
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        oe_nxt    = 1'b0;
                        state_nxt = WR_DATA;
                    end
                end
                RD_DATA: begin
                    // bit_cnt counts bits already placed on the bus
                    if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            oe_nxt    = 1'b0;
                            cnt_nxt   = '0;
                            state_nxt = RD_ACK;
                        end else begin
                            oe_nxt  = ~shreg[6];
                            sh_nxt  = {shreg[6:0], 1'b0};
                            cnt_nxt = bit_cnt + 4'd1;
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_f) begin
                            busy_nxt  = 1'b0;
                            state_nxt = WAIT_STOP;
                        end else begin
                            tx_req_nxt = 1'b1;
                        end
                    end else if (scl_fall) begin
                        sh_nxt    = tx_data;
                        oe_nxt    = ~tx_data[7];
                        cnt_nxt   = 4'd1;
                        state_nxt = RD_DATA;
                    end
                end
                WAIT_STOP: oe_nxt = 1'b0;
                default:   state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave_port.sv
// Directed bench: bus master tasks plus a transaction-level model of the target's expected responses.
module tb_i2c_slave_port;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_i;
    logic       sda_m;
    logic       sda_i;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_first;
    logic       tx_req;
    logic [7:0] tx_data;
    logic       start_det;
    logic       stop_det;
    logic       busy;

    localparam int Q = 8;

    assign sda_i = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_slave_port dut (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .sda_oe    (sda_oe),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_first  (rx_first),
        .tx_req    (tx_req),
        .tx_data   (tx_data),
        .start_det (start_det),
        .stop_det  (stop_det),
        .busy      (busy)
    );

    int nvec = 0;
    int nerr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Transaction-level model of what the target must do.
    typedef struct {
        logic [7:0] d;
        logic       f;
    } rx_t;

    rx_t        exp_rx[$];
    logic [7:0] rx_log[$];
    logic       rxf_log[$];
    logic       m_busy = 1'b0;
    logic       m_addr_phase = 1'b0;
    logic       m_addressed = 1'b0;
    logic       m_read = 1'b0;
    logic       m_first = 1'b0;
    logic [7:0] m_tx = 8'h00;
    int exp_start = 0, exp_stop = 0, exp_txreq = 0;
    int got_start = 0, got_stop = 0, got_txreq = 0;

    task automatic model_byte(input logic [7:0] b, output logic exp_ack);
        if (m_addr_phase) begin
            m_addr_phase = 1'b0;
            if (b[7:1] == 7'h41) begin
                m_addressed = 1'b1;
                m_busy      = 1'b1;
                m_read      = b[0];
                m_first     = 1'b1;
                exp_txreq++;
                exp_ack     = 1'b1;
            end else begin
                m_addressed = 1'b0;
                m_busy      = 1'b0;
                exp_ack     = 1'b0;
            end
        end else if (m_addressed && !m_read) begin
            exp_rx.push_back('{d: b, f: m_first});
            m_first = 1'b0;
            exp_ack = 1'b1;
        end else begin
            exp_ack = 1'b0;
        end
    endtask

    // Per-cycle compare process
    int   scl_hi_cnt = 0;
    logic oe_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if (start_det) got_start++;
            if (stop_det)  got_stop++;
            if (tx_req)    got_txreq++;
            if (rx_valid) begin
                rx_log.push_back(rx_data);
                rxf_log.push_back(rx_first);
                if (exp_rx.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL rx_unexpected: got byte 0x%0h, no byte expected", rx_data);
                end else begin
                    rx_t e;
                    e = exp_rx.pop_front();
                    check("rx_data", {24'h0, rx_data}, {24'h0, e.d});
                    check("rx_first", {31'h0, rx_first}, {31'h0, e.f});
                end
                if (start_det || stop_det) begin
                    nvec++;
                    nerr++;
                    $display("FAIL rx_vs_startstop: rx_valid=1 with start_det=%0b stop_det=%0b", start_det, stop_det);
                end
            end
            if (sda_oe && !oe_prev && scl_hi_cnt >= Q) begin
                nvec++;
                nerr++;
                $display("FAIL oe_while_scl_high: sda_oe rose after SCL high %0d cycles", scl_hi_cnt);
            end
        end
        oe_prev    = sda_oe;
        scl_hi_cnt = scl_i ? scl_hi_cnt + 1 : 0;
    end

    // Bus master
    task automatic qwait();
        repeat (Q) @(posedge clk);
        #1;
    endtask

    task automatic clk_bit(input logic b, output logic s);
        qwait(); sda_m = b;
        qwait(); scl_i = 1'b1;
        qwait(); s = sda_i;
        qwait(); scl_i = 1'b0;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        qwait(); scl_i = 1'b1;
        qwait(); sda_m = 1'b0;
        qwait(); scl_i = 1'b0;
        exp_start++;
        m_addr_phase = 1'b1;
    endtask

    task automatic i2c_stop();
        qwait(); sda_m = 1'b0;
        qwait(); scl_i = 1'b1;
        qwait(); sda_m = 1'b1;
        qwait(); qwait();
        exp_stop++;
        m_busy       = 1'b0;
        m_addressed  = 1'b0;
        m_addr_phase = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        logic s;
        for (int i = 0; i < n; i++) clk_bit(b[7-i], s);
    endtask

    task automatic write_byte(input logic [7:0] b, input string name);
        logic exp_ack, s;
        model_byte(b, exp_ack);
        send_bits(b, 8);
        clk_bit(1'b1, s);
        check(name, {31'h0, ~s}, {31'h0, exp_ack});
        if (m_addressed && m_read) m_tx = tx_data;
    endtask

    task automatic read_byte(input logic [7:0] next_tx, input logic nack, input string name,
                             output logic [7:0] got);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, s);
            got[i] = s;
        end
        check(name, {24'h0, got}, {24'h0, m_tx});
        qwait(); sda_m = nack;
        qwait(); scl_i = 1'b1;
        qwait(); tx_data = next_tx;
        qwait(); scl_i = 1'b0;
        if (!nack) begin
            exp_txreq++;
            m_tx = next_tx;
        end else begin
            m_busy      = 1'b0;
            m_addressed = 1'b0;
        end
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_start_cnt"}, got_start, exp_start);
        check({tag, "_stop_cnt"}, got_stop, exp_stop);
        check({tag, "_txreq_cnt"}, got_txreq, exp_txreq);
        check({tag, "_rx_pending"}, exp_rx.size(), 0);
        check({tag, "_busy"}, {31'h0, busy}, {31'h0, m_busy});
    endtask

    logic [7:0] g0, g1;
    int         base;

    initial begin
        rst     = 1'b1;
        scl_i   = 1'b1;
        sda_m   = 1'b1;
        tx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", {rx_data, sda_oe, rx_valid, rx_first, tx_req, start_det, stop_det, busy}, 0);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("idle_outs", {rx_data, sda_oe, rx_valid, rx_first, tx_req, start_det, stop_det, busy}, 0);

        // Write 0x82, 0x42, 0x81, STOP
        i2c_start();
        write_byte(8'h82, "t1_addr_ack");
        check("t1_busy_on", {31'h0, busy}, 32'd1);
        write_byte(8'h42, "t1_d0_ack");
        write_byte(8'h81, "t1_d1_ack");
        i2c_stop();
        check_counts("t1");
        check("t1_rx_count", rx_log.size(), 2);
        if (rx_log.size() >= 2) begin
            check("t1_lit_d0", {24'h0, rx_log[0]}, 32'h42);
            check("t1_lit_f0", {31'h0, rxf_log[0]}, 32'd1);
            check("t1_lit_d1", {24'h0, rx_log[1]}, 32'h81);
            check("t1_lit_f1", {31'h0, rxf_log[1]}, 32'd0);
        end

        // Address mismatch 0x90, then a byte that must not be delivered
        i2c_start();
        write_byte(8'h90, "t2_addr_nack");
        check("t2_busy", {31'h0, busy}, 32'd0);
        write_byte(8'h11, "t2_data_nack");
        i2c_stop();
        check_counts("t2");

        // Read two bytes: ACK the first, NACK the second
        tx_data = 8'hA5;
        i2c_start();
        write_byte(8'h83, "t3_addr_ack");
        read_byte(8'h3C, 1'b0, "t3_rd0", g0);
        read_byte(8'h00, 1'b1, "t3_rd1", g1);
        check("t3_lit_rd0", {24'h0, g0}, 32'hA5);
        check("t3_lit_rd1", {24'h0, g1}, 32'h3C);
        qwait();
        check("t3_oe_wait_stop", {31'h0, sda_oe}, 32'd0);
        check("t3_busy_after_nack", {31'h0, busy}, 32'd0);
        i2c_stop();
        check_counts("t3");

        // Write, repeated START, read one byte
        base = rx_log.size();
        i2c_start();
        write_byte(8'h82, "t4_waddr_ack");
        write_byte(8'h55, "t4_d0_ack");
        tx_data = 8'h6E;
        i2c_start();
        write_byte(8'h83, "t4_raddr_ack");
        read_byte(8'h00, 1'b1, "t4_rd0", g0);
        check("t4_lit_rd0", {24'h0, g0}, 32'h6E);
        i2c_stop();
        check_counts("t4");
        check("t4_rx_count", rx_log.size() - base, 1);
        if (rx_log.size() > base) check("t4_lit_d0", {24'h0, rx_log[base]}, 32'h55);

        // STOP after 4 bits of a data byte
        base = rx_log.size();
        i2c_start();
        write_byte(8'h82, "t5_addr_ack");
        send_bits(8'hF0, 4);
        i2c_stop();
        check("t5_oe", {31'h0, sda_oe}, 32'd0);
        check("t5_rx_count", rx_log.size() - base, 0);
        check_counts("t5");

        // One-clock SDA glitch while SCL is high
        @(negedge clk); sda_m = 1'b0;
        @(negedge clk); sda_m = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check_counts("glitch");

        // Async reset while the target is acking a write byte
        begin
            logic a;
            i2c_start();
            write_byte(8'h82, "t6_addr_ack");
            model_byte(8'h99, a);
            send_bits(8'h99, 8);
            qwait();
            check("t6_oe_in_ack", {31'h0, sda_oe}, 32'd1);
            #3 rst = 1'b1;
            #1;
            check("t6_oe_async", {31'h0, sda_oe}, 32'd0);
            check("t6_busy_rst", {31'h0, busy}, 32'd0);
            m_busy       = 1'b0;
            m_addressed  = 1'b0;
            m_addr_phase = 1'b0;
            scl_i = 1'b1;
            sda_m = 1'b1;
            repeat (5) @(posedge clk);
            #1 rst = 1'b0;
            repeat (10) @(posedge clk);
            #1;
        end
        base = rx_log.size();
        i2c_start();
        write_byte(8'h82, "t6b_addr_ack");
        write_byte(8'h3A, "t6b_d0_ack");
        i2c_stop();
        check_counts("t6b");
        check("t6b_rx_count", rx_log.size() - base, 1);
        if (rx_log.size() > base) begin
            check("t6b_lit_d0", {24'h0, rx_log[base]}, 32'h3A);
            check("t6b_lit_f0", {31'h0, rxf_log[base]}, 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
